// File: rtl/alu_pipe.sv
// Registered, valid/ready handshaked Hack-style ALU with logical shifts and an
// optional iterative shift-add multiply (WIDTH cycles per product).
module alu_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned DW = 2 * WIDTH;
    localparam logic [1:0]  MODE_MUL = 2'b01;
    localparam logic [1:0]  MODE_SHL = 2'b10;
    localparam logic [1:0]  MODE_SHR = 2'b11;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q;
    logic [DW-1:0]    x_sh_q;
    logic [DW-1:0]    acc_q;
    logic [WIDTH-1:0] y_sh_q;
    logic [SW-1:0]    cnt_q;
    logic             done_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic             zr_q;
    logic             ng_q;
    logic             cy_q;

    logic             out_free;
    logic             accept;
    logic             is_mul;
    logic             mul_last;
    logic [WIDTH-1:0] xh;
    logic [WIDTH-1:0] yh;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [SW-1:0]    shamt;
    logic             shift_big;
    logic [WIDTH-1:0] op_res;
    logic             op_cy;
    logic [DW-1:0]    mul_add;
    logic [DW-1:0]    mul_val;
    logic             ld_en;
    logic [WIDTH-1:0] ld_res;
    logic             ld_cy;

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = !reset && (state_q == S_IDLE) && out_free;
    assign accept    = in_valid && in_ready;
    assign is_mul    = MUL_EN && (mode == MODE_MUL);

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign cy        = cy_q;

    // Single-cycle datapath: Hack function set and logical shifts.
    always_comb begin
        xh        = ctrl[5] ? '0 : x;
        xh        = ctrl[4] ? ~xh : xh;
        yh        = ctrl[3] ? '0 : y;
        yh        = ctrl[2] ? ~yh : yh;
        sum       = {1'b0, xh} + {1'b0, yh};
        shamt     = y[SW-1:0];
        shift_big = |y[WIDTH-1:SW];
        shl_w     = {1'b0, x} << shamt;
        shr_w     = {x, 1'b0} >> shamt;
        op_res    = '0;
        op_cy     = 1'b0;
        case (mode)
            MODE_SHL: begin
                op_res = shift_big ? '0 : shl_w[WIDTH-1:0];
                op_cy  = !shift_big && shl_w[WIDTH];
            end
            MODE_SHR: begin
                op_res = shift_big ? '0 : shr_w[WIDTH:1];
                op_cy  = !shift_big && shr_w[0];
            end
            default: begin
                op_res = ctrl[1] ? sum[WIDTH-1:0] : (xh & yh);
                op_res = ctrl[0] ? ~op_res : op_res;
                op_cy  = ctrl[1] && sum[WIDTH];
            end
        endcase
    end

    // Multiply step and output-register load selection.
    always_comb begin
        mul_add  = y_sh_q[0] ? (acc_q + x_sh_q) : acc_q;
        mul_val  = done_q ? acc_q : mul_add;
        mul_last = (state_q == S_MUL) && (done_q || (cnt_q == SW'(WIDTH - 1)));
        ld_en    = (accept && !is_mul) || (mul_last && out_free);
        ld_res   = (state_q == S_MUL) ? mul_val[WIDTH-1:0] : op_res;
        ld_cy    = (state_q == S_MUL) ? (|mul_val[DW-1:WIDTH]) : op_cy;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_sh_q      <= '0;
            acc_q       <= '0;
            y_sh_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
            cy_q        <= 1'b0;
        end else begin
            if (ld_en) begin
                out_valid_q <= 1'b1;
                out_q       <= ld_res;
                zr_q        <= (ld_res == '0);
                ng_q        <= ld_res[WIDTH-1];
                cy_q        <= ld_cy;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept && is_mul) begin
                        state_q <= S_MUL;
                        x_sh_q  <= DW'(x);
                        y_sh_q  <= y;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (mul_last) begin
                        // Final product waits here until the output register frees up.
                        if (out_free) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            done_q  <= 1'b1;
                            acc_q   <= mul_val;
                        end
                    end else begin
                        acc_q  <= mul_add;
                        x_sh_q <= x_sh_q << 1;
                        y_sh_q <= y_sh_q >> 1;
                        cnt_q  <= cnt_q + SW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases with literal expectations plus randomized
// traffic, all checked every cycle against a transaction-level reference model.
module tb_alu_pipe;

    localparam int unsigned W = 16;

    logic         clock     = 1'b0;
    logic         reset     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] x         = '0;
    logic [W-1:0] y         = '0;
    logic [5:0]   ctrl      = '0;
    logic [1:0]   mode      = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         zr;
    logic         ng;
    logic         cy;

    int tests = 0;
    int fails = 0;

    alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .ctrl      (ctrl),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng),
        .cy        (cy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference result {cy, out} computed directly from the arithmetic meaning of each mode.
    function automatic logic [W:0] ref_op(input logic [1:0] md, input logic [5:0] c,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] xa;
        logic [W-1:0] yb;
        logic [W-1:0] r;
        int unsigned  s;
        int unsigned  p;
        int unsigned  bi;
        bi = 32'(b);
        case (md)
            2'b01: begin
                p = 32'(a) * 32'(b);
                return {p[31:16] != 16'd0, p[15:0]};
            end
            2'b10: begin
                if (bi >= W) return '0;
                p = 32'(a) << bi;
                return {(bi != 0) && p[16], p[15:0]};
            end
            2'b11: begin
                if (bi >= W) return '0;
                r = a >> bi;
                if (bi == 0) return {1'b0, r};
                p = (32'(a) >> (bi - 1)) & 32'd1;
                return {p != 0, r};
            end
            default: begin
                xa = c[5] ? 16'd0 : a;
                if (c[4]) xa = ~xa;
                yb = c[3] ? 16'd0 : b;
                if (c[2]) yb = ~yb;
                s = 32'(xa) + 32'(yb);
                r = c[1] ? s[15:0] : (xa & yb);
                if (c[0]) r = ~r;
                return {c[1] && s[16], r};
            end
        endcase
    endfunction

    // Transaction-level model: an output slot plus a countdown for an in-flight multiply.
    logic         m_valid    = 1'b0;
    logic [W-1:0] m_out      = '0;
    logic         m_cy       = 1'b0;
    int           m_busy     = 0;
    logic [W-1:0] m_mul_out  = '0;
    logic         m_mul_cy   = 1'b0;
    logic         m_acc;
    logic         m_free;
    logic [W:0]   m_r;

    function automatic logic m_ready();
        return !reset && (m_busy == 0) && (!m_valid || out_ready);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0;
            m_out   = '0;
            m_cy    = 1'b0;
            m_busy  = 0;
        end else begin
            m_acc  = in_valid && m_ready();
            m_free = !m_valid || out_ready;
            if (out_ready) m_valid = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    if (m_free) begin
                        m_valid = 1'b1;
                        m_out   = m_mul_out;
                        m_cy    = m_mul_cy;
                    end else begin
                        m_busy = 1;
                    end
                end
            end
            if (m_acc) begin
                m_r = ref_op(mode, ctrl, x, y);
                if (mode == 2'b01) begin
                    m_busy    = W;
                    m_mul_out = m_r[W-1:0];
                    m_mul_cy  = m_r[W];
                end else begin
                    m_valid = 1'b1;
                    m_out   = m_r[W-1:0];
                    m_cy    = m_r[W];
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clock) begin
        check("in_ready", 32'(in_ready), 32'(m_ready()));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out", 32'(out), 32'(m_out));
            check("zr", 32'(zr), 32'(m_out == 16'd0));
            check("ng", 32'(ng), 32'(m_out[W-1]));
            check("cy", 32'(cy), 32'(m_cy));
        end
    end

    task automatic issue(input logic [1:0] md, input logic [5:0] c,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        mode = md; ctrl = c; x = a; y = b; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clock); #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string name, input int lat, input logic [W-1:0] eo,
                              input logic ezr, input logic eng, input logic ecy);
        int n = 1;
        @(negedge clock);
        while (!out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({name, "_lat"}, 32'(n), 32'(lat));
        check({name, "_out"}, 32'(out), 32'(eo));
        check({name, "_zr"}, 32'(zr), 32'(ezr));
        check({name, "_ng"}, 32'(ng), 32'(eng));
        check({name, "_cy"}, 32'(cy), 32'(ecy));
        #1;
    endtask

    logic   last_acc = 1'b0;
    longint t0;

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_flags", {29'd0, zr, ng, cy}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        #1 reset = 1'b0;
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Hack arithmetic
        issue(2'b00, 6'b000010, 16'd5, 16'd7);
        expect_res("add", 1, 16'd12, 1'b0, 1'b0, 1'b0);
        issue(2'b00, 6'b010011, 16'd3, 16'd5);
        expect_res("sub", 1, 16'hFFFE, 1'b0, 1'b1, 1'b1);
        issue(2'b00, 6'b101010, 16'd9, 16'd4);
        expect_res("zero", 1, 16'd0, 1'b1, 1'b0, 1'b0);
        issue(2'b00, 6'b000010, 16'hFFFF, 16'd1);
        expect_res("wrap", 1, 16'd0, 1'b1, 1'b0, 1'b1);

        // Back-to-back throughput
        t0 = $time;
        issue(2'b00, 6'b000000, 16'h00F0, 16'h0FF0);
        issue(2'b10, 6'b000000, 16'h1234, 16'd4);
        issue(2'b00, 6'b001111, 16'h0000, 16'h0002);
        check("b2b_time", 32'($time - t0), 32'd25);
        repeat (2) @(negedge clock);
        #1;

        // Backpressure: A held, B waits, then A drains as B loads
        out_ready = 1'b0;
        issue(2'b00, 6'b000010, 16'd5, 16'd7);
        mode = 2'b00; ctrl = 6'b000010; x = 16'd100; y = 16'd1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_hold_out", 32'(out), 32'd12);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        #1 out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("bp_b_out", 32'(out), 32'd101);
        check("bp_b_valid", 32'(out_valid), 32'd1);
        @(negedge clock);
        check("bp_no_dup", 32'(out_valid), 32'd0);
        #1;

        // Multiply
        issue(2'b01, 6'b000000, 16'd300, 16'd300);
        expect_res("mul_ovf", 17, 16'h5F90, 1'b0, 1'b0, 1'b1);
        issue(2'b01, 6'b111111, 16'd7, 16'd6);
        expect_res("mul_small", 17, 16'd42, 1'b0, 1'b0, 1'b0);

        // Shifts
        issue(2'b10, 6'b000000, 16'h8001, 16'd1);
        expect_res("shl1", 1, 16'h0002, 1'b0, 1'b0, 1'b1);
        issue(2'b11, 6'b000000, 16'h0003, 16'd1);
        expect_res("shr1", 1, 16'h0001, 1'b0, 1'b0, 1'b1);
        issue(2'b10, 6'b000000, 16'h1234, 16'd16);
        expect_res("shl16", 1, 16'd0, 1'b1, 1'b0, 1'b0);
        issue(2'b11, 6'b000000, 16'h8000, 16'd15);
        expect_res("shr15", 1, 16'd1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a multiply
        issue(2'b01, 6'b000000, 16'd7, 16'd6);
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("midmul_valid", 32'(out_valid), 32'd0);
        check("midmul_out", 32'(out), 32'd0);
        check("midmul_cy", 32'(cy), 32'd0);
        check("midmul_ready", 32'(in_ready), 32'd0);
        @(negedge clock); #1;
        reset = 1'b0;
        issue(2'b00, 6'b000010, 16'd1, 16'd1);
        expect_res("after_rst", 1, 16'd2, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with random consumer stalls
        for (int i = 0; i < 800; i++) begin
            @(negedge clock); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 2) != 0);
                mode     = 2'($urandom_range(0, 3));
                ctrl     = 6'($urandom);
                x        = 16'($urandom);
                y        = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
            end
            #1 last_acc = in_valid && in_ready;
        end
        @(negedge clock); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
